// File: rtl/x3_to_bin_seq.sv
// Excess-3 frame sequencer: collects NDIG excess-3 digits (MSD first), accumulates
// them into a binary value and hands the result plus first-error position downstream.
module x3_to_bin_seq #(
  parameter int NDIG  = 4,
  parameter int OUT_W = 14,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       digit_in,
  input  logic             digit_valid,
  output logic             digit_ready,
  output logic             busy,
  output logic [OUT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             err_invalid,
  output logic [IDX_W-1:0] err_index
);

  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t           state_reg;
  logic [OUT_W-1:0] acc_reg;
  logic [OUT_W-1:0] acc_next;
  logic [CNT_W-1:0] count_reg;
  logic             code_ok;
  logic [3:0]       digit_dec;
  logic             last_digit;

  // Invalid codes contribute a zero digit but still occupy their slot in the frame.
  always_comb begin
    code_ok    = (digit_in >= 4'd3) && (digit_in <= 4'd12);
    digit_dec  = code_ok ? (digit_in - 4'd3) : 4'd0;
    acc_next   = (acc_reg << 3) + (acc_reg << 1) + OUT_W'(digit_dec);
    last_digit = (count_reg == CNT_W'(NDIG - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      count_reg    <= '0;
      result       <= '0;
      err_invalid  <= 1'b0;
      err_index    <= '0;
      digit_ready  <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= COLLECT;
            acc_reg     <= '0;
            count_reg   <= '0;
            err_invalid <= 1'b0;
            err_index   <= '0;
            digit_ready <= 1'b1;
            busy        <= 1'b1;
          end
        end
        COLLECT: begin
          if (digit_valid) begin
            acc_reg <= acc_next;
            if (!code_ok && !err_invalid) begin
              err_invalid <= 1'b1;
              err_index   <= IDX_W'(count_reg);
            end
            if (last_digit) begin
              state_reg    <= DONE;
              result       <= acc_next;
              count_reg    <= '0;
              digit_ready  <= 1'b0;
              result_valid <= 1'b1;
            end else begin
              count_reg <= count_reg + 1'b1;
            end
          end
        end
        DONE: begin
          // start is deliberately not looked at here, even on the handshake edge.
          if (result_ready) begin
            state_reg    <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state_reg    <= IDLE;
          digit_ready  <= 1'b0;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x3_to_bin_seq.sv
// Bench for x3_to_bin_seq: frame-level arithmetic model checked every cycle,
// plus literal expectations for the directed frames.
module tb_x3_to_bin_seq;

  localparam int NDIG  = 4;
  localparam int OUT_W = 14;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       digit_in = 4'd0;
  logic             digit_valid = 1'b0;
  logic             digit_ready;
  logic             busy;
  logic [OUT_W-1:0] result;
  logic             result_valid;
  logic             result_ready = 1'b0;
  logic             err_invalid;
  logic [IDX_W-1:0] err_index;

  int tests = 0;
  int fails = 0;

  x3_to_bin_seq #(.NDIG(NDIG), .OUT_W(OUT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .start(start), .digit_in(digit_in),
    .digit_valid(digit_valid), .digit_ready(digit_ready), .busy(busy),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .err_invalid(err_invalid), .err_index(err_index)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  function automatic int dec(input logic [3:0] c);
    return (c >= 3 && c <= 12) ? int'(c) - 3 : 0;
  endfunction

  function automatic int frame_value(input logic [3:0] c[NDIG], input logic [3:0] last);
    int v = 0;
    for (int i = 0; i < NDIG; i++)
      v = v * 10 + dec((i == NDIG - 1) ? last : c[i]);
    return v % (1 << OUT_W);
  endfunction

  function automatic int first_bad(input logic [3:0] c[NDIG], input logic [3:0] last);
    logic [3:0] x;
    for (int i = 0; i < NDIG; i++) begin
      x = (i == NDIG - 1) ? last : c[i];
      if (x < 3 || x > 12) return i;
    end
    return -1;
  endfunction

  int               m_phase;   // 0 waiting for start, 1 taking digits, 2 offering result
  int               m_n;
  logic [3:0]       m_codes[NDIG];
  int               m_result;
  int               m_err;
  int               m_idx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase  <= 0;
      m_n      <= 0;
      m_result <= 0;
      m_err    <= 0;
      m_idx    <= 0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1;
          m_n     <= 0;
        end
        1: if (digit_valid) begin
          m_codes[m_n] <= digit_in;
          m_n          <= m_n + 1;
          if (m_n == NDIG - 1) begin
            m_phase  <= 2;
            m_result <= frame_value(m_codes, digit_in);
            m_err    <= (first_bad(m_codes, digit_in) >= 0) ? 1 : 0;
            m_idx    <= (first_bad(m_codes, digit_in) >= 0) ? first_bad(m_codes, digit_in) : 0;
          end
        end
        default: if (result_ready) m_phase <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("digit_ready", int'(digit_ready), (m_phase == 1) ? 1 : 0);
      chk("busy", int'(busy), (m_phase != 0) ? 1 : 0);
      chk("result_valid", int'(result_valid), (m_phase == 2) ? 1 : 0);
      if (m_phase == 2) begin
        chk("result", int'(result), m_result);
        chk("err_invalid", int'(err_invalid), m_err);
        chk("err_index", int'(err_index), m_idx);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0] codes[NDIG], input int maxgap, input bit poke_start);
    for (int i = 0; i < NDIG; i++) begin
      int gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      repeat (gap) @(negedge clk);
      digit_in    = codes[i];
      digit_valid = 1'b1;
      start       = poke_start && (i == 1);
      @(negedge clk);
      digit_valid = 1'b0;
      start       = 1'b0;
    end
  endtask

  task automatic take_result(input string tag, input int hold,
                             input int exp_res, input int exp_err, input int exp_idx);
    for (int i = 0; i < 50 && !result_valid; i++) @(negedge clk);
    chk({tag, "_valid"}, int'(result_valid), 1);
    for (int i = 0; i < hold; i++) begin
      chk({tag, "_hold_ready"}, int'(digit_ready), 0);
      chk({tag, "_hold_res"}, int'(result), exp_res);
      @(negedge clk);
    end
    chk({tag, "_res"}, int'(result), exp_res);
    chk({tag, "_err"}, int'(err_invalid), exp_err);
    chk({tag, "_idx"}, int'(err_index), exp_idx);
    $display("[TB] %s: result=%0d err_invalid=%0d err_index=%0d", tag, result, err_invalid, err_index);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({tag, "_idle_busy"}, int'(busy), 0);
    chk({tag, "_idle_rv"}, int'(result_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", int'(result), 0);
    chk("rst_rv", int'(result_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(digit_ready), 0);
    chk("rst_err", int'(err_invalid), 0);
    chk("rst_idx", int'(err_index), 0);
    rst = 1'b0;
    @(negedge clk);

    // T1: 1,3,7,2 back-to-back
    pulse_start();
    send_frame('{4'b0100, 4'b0110, 4'b1010, 4'b0101}, 0, 1'b0);
    chk("t1_latency", int'(result_valid), 1);
    take_result("t1", 0, 1372, 0, 0);

    // T2: all nines, start poked mid-frame
    pulse_start();
    send_frame('{4'b1100, 4'b1100, 4'b1100, 4'b1100}, 0, 1'b1);
    take_result("t2", 0, 9999, 0, 0);

    // T3: invalid digits at positions 1 and 3
    pulse_start();
    send_frame('{4'b0011, 4'b1111, 4'b0100, 4'b0000}, 0, 1'b0);
    take_result("t3", 0, 10, 1, 1);

    // T4: gapped digits, consumer stalls 5 cycles
    pulse_start();
    send_frame('{4'b1000, 4'b0011, 4'b1011, 4'b0111}, 3, 1'b0);
    take_result("t4", 5, 5084, 0, 0);

    // T5: reset mid-frame, then a fresh frame
    pulse_start();
    digit_in = 4'b0101; digit_valid = 1'b1;
    repeat (2) @(negedge clk);
    digit_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_ready", int'(digit_ready), 0);
    chk("t5_rst_rv", int'(result_valid), 0);
    chk("t5_rst_result", int'(result), 0);
    chk("t5_rst_err", int'(err_invalid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    send_frame('{4'b0011, 4'b0011, 4'b0011, 4'b0100}, 0, 1'b0);
    take_result("t5", 0, 1, 0, 0);

    // T6: start held across DONE->IDLE, digits offered in IDLE
    pulse_start();
    send_frame('{4'b0100, 4'b0101, 4'b0110, 4'b0111}, 0, 1'b0);
    for (int i = 0; i < 50 && !result_valid; i++) @(negedge clk);
    chk("t6_valid", int'(result_valid), 1);
    chk("t6_res", int'(result), 1234);
    start = 1'b1; result_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; result_ready = 1'b0;
    chk("t6_idle_busy", int'(busy), 0);
    digit_in = 4'b1100; digit_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_idle_ready", int'(digit_ready), 0);
    chk("t6_idle_busy2", int'(busy), 0);
    digit_valid = 1'b0;
    pulse_start();
    send_frame('{4'b0100, 4'b0100, 4'b0100, 4'b0100}, 1, 1'b0);
    take_result("t6", 2, 1111, 0, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
